matrix_rx_loader: RTL and testbench

- Sits between the UART receiver and the matrix multiplier in `top`.
- Parses the incoming byte stream: one size byte N, then N*N bytes of A in row-major order, then N*N bytes of B in row-major order.
- Writes each element into the A or B operand buffer and pulses `load_done` to start multiplication.
- Holds off new frames until the multiplier reports `mult_done`, and flags malformed, stalled or overrunning input.

---
 rtl/matrix_rx_loader.sv | 180 ++++++++++++++++++
 tb/tb_matrix_rx_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_rx_loader.sv
// Parses a UART byte stream (size N, N*N A elements, N*N B elements) into operand buffer writes.
// Latency: 1 cycle from rx_valid to write strobe; load_done coincides with the final B write.
// Backpressure: none on rx; bytes arriving while the multiplier is busy are dropped and flagged.
module matrix_rx_loader #(
    parameter int MAX_N          = 8,
    parameter int DW             = 8,
    parameter int AW             = 6,
    parameter int RCW            = 3,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  rx_data,
    input  logic           rx_valid,
    input  logic           mult_done,
    output logic           a_we,
    output logic           b_we,
    output logic [AW-1:0]  wr_addr,
    output logic [RCW-1:0] wr_row,
    output logic [RCW-1:0] wr_col,
    output logic [DW-1:0]  wr_data,
    output logic [RCW:0]   mat_size,
    output logic           load_done,
    output logic           busy,
    output logic           err_size,
    output logic           err_timeout,
    output logic           err_overrun
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, WAIT_MULT} state_t;

    localparam int NNW = 2 * RCW + 2;
    localparam int CW  = (AW > NNW) ? AW : NNW;

    state_t         state, state_nx;
    logic [RCW-1:0] row, row_nx, col, col_nx;
    logic [AW-1:0]  idx, idx_nx;
    logic [31:0]    tmo_cnt, tmo_cnt_nx;

    logic           a_we_nx, b_we_nx, load_done_nx, busy_nx;
    logic [AW-1:0]  wr_addr_nx;
    logic [RCW-1:0] wr_row_nx, wr_col_nx;
    logic [DW-1:0]  wr_data_nx;
    logic [RCW:0]   mat_size_nx;
    logic           err_size_nx, err_timeout_nx, err_overrun_nx;

    logic [NNW-1:0] nn;
    logic           last_elem, col_last, size_ok, tmo_hit;

    assign nn        = NNW'(mat_size) * NNW'(mat_size);
    assign last_elem = (CW'(idx) == CW'(nn) - CW'(1));
    assign col_last  = ((RCW+1)'(col) == mat_size - (RCW+1)'(1));
    assign size_ok   = (rx_data != '0) && (rx_data <= DW'(MAX_N));
    // A zero timeout setting must never match the (wrapping) counter.
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx       = state;
        row_nx         = row;
        col_nx         = col;
        idx_nx         = idx;
        tmo_cnt_nx     = '0;
        a_we_nx        = 1'b0;
        b_we_nx        = 1'b0;
        load_done_nx   = 1'b0;
        wr_addr_nx     = wr_addr;
        wr_row_nx      = wr_row;
        wr_col_nx      = wr_col;
        wr_data_nx     = wr_data;
        mat_size_nx    = mat_size;
        busy_nx        = busy;
        err_size_nx    = err_size;
        err_timeout_nx = err_timeout;
        err_overrun_nx = err_overrun;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (size_ok) begin
                        mat_size_nx    = rx_data[RCW:0];
                        err_size_nx    = 1'b0;
                        err_timeout_nx = 1'b0;
                        err_overrun_nx = 1'b0;
                        row_nx         = '0;
                        col_nx         = '0;
                        idx_nx         = '0;
                        busy_nx        = 1'b1;
                        state_nx       = LOAD_A;
                    end else begin
                        err_size_nx = 1'b1;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (rx_valid) begin
                    a_we_nx    = (state == LOAD_A);
                    b_we_nx    = (state == LOAD_B);
                    wr_addr_nx = idx;
                    wr_row_nx  = row;
                    wr_col_nx  = col;
                    wr_data_nx = rx_data;
                    if (last_elem) begin
                        row_nx = '0;
                        col_nx = '0;
                        idx_nx = '0;
                        if (state == LOAD_A) begin
                            state_nx = LOAD_B;
                        end else begin
                            load_done_nx = 1'b1;
                            state_nx     = WAIT_MULT;
                        end
                    end else begin
                        idx_nx = idx + AW'(1);
                        if (col_last) begin
                            col_nx = '0;
                            row_nx = row + RCW'(1);
                        end else begin
                            col_nx = col + RCW'(1);
                        end
                    end
                end else if (tmo_hit) begin
                    err_timeout_nx = 1'b1;
                    busy_nx        = 1'b0;
                    state_nx       = IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 32'd1;
                end
            end
            WAIT_MULT: begin
                if (rx_valid) err_overrun_nx = 1'b1;
                if (mult_done) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            a_we        <= 1'b0;
            b_we        <= 1'b0;
            load_done   <= 1'b0;
            wr_addr     <= '0;
            wr_row      <= '0;
            wr_col      <= '0;
            wr_data     <= '0;
            mat_size    <= '0;
            busy        <= 1'b0;
            err_size    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nx;
            row         <= row_nx;
            col         <= col_nx;
            idx         <= idx_nx;
            tmo_cnt     <= tmo_cnt_nx;
            a_we        <= a_we_nx;
            b_we        <= b_we_nx;
            load_done   <= load_done_nx;
            wr_addr     <= wr_addr_nx;
            wr_row      <= wr_row_nx;
            wr_col      <= wr_col_nx;
            wr_data     <= wr_data_nx;
            mat_size    <= mat_size_nx;
            busy        <= busy_nx;
            err_size    <= err_size_nx;
            err_timeout <= err_timeout_nx;
            err_overrun <= err_overrun_nx;
        end
    end

endmodule

// File: tb/tb_matrix_rx_loader.sv
// Self-checking bench for matrix_rx_loader: expected writes are queued as bytes are driven
// and matched against every observed write strobe.
module tb_matrix_rx_loader;

    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       mult_done = 1'b0;
    logic       a_we, b_we, load_done, busy;
    logic       err_size, err_timeout, err_overrun;
    logic [5:0] wr_addr;
    logic [2:0] wr_row, wr_col;
    logic [7:0] wr_data;
    logic [3:0] mat_size;

    typedef struct {
        logic       is_b;
        logic [5:0] addr;
        logic [2:0] row;
        logic [2:0] col;
        logic [7:0] data;
        logic       ld;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] da [64];
    logic [7:0] db [64];

    matrix_rx_loader #(
        .MAX_N(8), .DW(8), .AW(6), .RCW(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .mult_done(mult_done), .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .mat_size(mat_size),
        .load_done(load_done), .busy(busy), .err_size(err_size),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // All tasks start and end at posedge+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_matrix(input logic is_b, input int n, input logic [7:0] d [64]);
        exp_t e;
        for (int i = 0; i < n * n; i++) begin
            e.is_b = is_b;
            e.addr = 6'(i);
            e.row  = 3'(i / n);
            e.col  = 3'(i % n);
            e.data = d[i];
            e.ld   = is_b && (i == n * n - 1);
            exp_q.push_back(e);
            send_byte(d[i]);
        end
    endtask

    task automatic rand_data(input int n);
        for (int i = 0; i < n * n; i++) begin
            da[i] = 8'($urandom_range(0, 255));
            db[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic finish_frame(input string tag);
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_missing: %0d writes outstanding, required 0", tag, exp_q.size());
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_wait: busy=%b required 1", tag, busy);
        end
        mult_done = 1'b1;
        step();
        mult_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_release: busy=%b required 0", tag, busy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [32:0] obs;
        obs = {a_we, b_we, load_done, busy, err_size, err_timeout, err_overrun,
               wr_addr, wr_row, wr_col, wr_data, mat_size};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s_outputs_zero: got %h required 0", tag, obs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_3x3();
        logic [71:0] pa, pb;
        pa = 72'h010203040304040304;
        pb = 72'h050607080708080708;
        for (int i = 0; i < 9; i++) begin
            da[i] = pa[71 - 8 * i -: 8];
            db[i] = pb[71 - 8 * i -: 8];
        end
        send_byte(8'h03);
        checks++;
        if (busy !== 1'b1 || mat_size !== 4'd3) begin
            errors++;
            $display("FAIL t1_size_accept: busy=%b mat_size=%0d required 1/3", busy, mat_size);
        end
        send_matrix(1'b0, 3, da);
        send_matrix(1'b1, 3, db);
        finish_frame("t1");
    endtask

    task automatic test_bad_size();
        send_byte(8'h00);
        checks++;
        if (err_size !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t2_size0: err_size=%b busy=%b required 1/0", err_size, busy);
        end
        send_byte(8'h09);
        checks++;
        if (err_size !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t2_size9: err_size=%b busy=%b required 1/0", err_size, busy);
        end
        send_byte(8'h02);
        checks++;
        if (err_size !== 1'b0 || mat_size !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t2_size2: err_size=%b mat_size=%0d busy=%b required 0/2/1",
                     err_size, mat_size, busy);
        end
        rand_data(2);
        send_matrix(1'b0, 2, da);
        send_matrix(1'b1, 2, db);
        finish_frame("t2");
    endtask

    task automatic test_timeout();
        exp_t e;
        int   cyc;
        send_byte(8'h02);
        for (int i = 0; i < 2; i++) begin
            e.is_b = 1'b0;
            e.addr = 6'(i);
            e.row  = 3'd0;
            e.col  = 3'(i);
            e.data = 8'(8'hA0 + i);
            e.ld   = 1'b0;
            exp_q.push_back(e);
            send_byte(e.data);
        end
        cyc = 0;
        for (int k = 1; k <= 2 * TMO; k++) begin
            step();
            if (err_timeout === 1'b1) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc != TMO) begin
            errors++;
            $display("FAIL t3_timeout_cycles: rose after %0d cycles (0=never) required %0d", cyc, TMO);
        end
        checks++;
        if (busy !== 1'b0 || mat_size !== 4'd2) begin
            errors++;
            $display("FAIL t3_after_timeout: busy=%b mat_size=%0d required 0/2", busy, mat_size);
        end
        send_byte(8'h02);
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL t3_resize: busy=%b err_timeout=%b required 1/0", busy, err_timeout);
        end
        rand_data(2);
        send_matrix(1'b0, 2, da);
        send_matrix(1'b1, 2, db);
        finish_frame("t3");
    endtask

    task automatic test_overrun();
        rand_data(1);
        send_byte(8'h01);
        send_matrix(1'b0, 1, da);
        send_matrix(1'b1, 1, db);
        step();
        send_byte(8'h55);
        step();
        checks++;
        if (err_overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_overrun: err_overrun=%b busy=%b required 1/1", err_overrun, busy);
        end
        rx_data   = 8'h66;
        rx_valid  = 1'b1;
        mult_done = 1'b1;
        step();
        rx_valid  = 1'b0;
        mult_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL t4_same_cycle: busy=%b err_overrun=%b required 0/1", busy, err_overrun);
        end
        send_byte(8'h02);
        checks++;
        if (mat_size !== 4'd2 || busy !== 1'b1 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle_after: mat_size=%0d busy=%b err_overrun=%b required 2/1/0",
                     mat_size, busy, err_overrun);
        end
        rand_data(2);
        send_matrix(1'b0, 2, da);
        send_matrix(1'b1, 2, db);
        finish_frame("t4");
    endtask

    task automatic test_reset_mid_load();
        exp_t e;
        rand_data(3);
        send_byte(8'h03);
        send_matrix(1'b0, 3, da);
        for (int i = 0; i < 2; i++) begin
            e.is_b = 1'b1;
            e.addr = 6'(i);
            e.row  = 3'd0;
            e.col  = 3'(i);
            e.data = db[i];
            e.ld   = 1'b0;
            exp_q.push_back(e);
            send_byte(db[i]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("t5");
        step();
        rand_data(3);
        send_byte(8'h03);
        send_matrix(1'b0, 3, da);
        send_matrix(1'b1, 3, db);
        finish_frame("t5");
    endtask

    task automatic test_size1();
        da[0] = 8'h7F;
        db[0] = 8'h80;
        send_byte(8'h01);
        send_matrix(1'b0, 1, da);
        send_matrix(1'b1, 1, db);
        finish_frame("t6");
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (a_we || b_we) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: a_we=%b b_we=%b addr=%0d data=%h required no write",
                                 a_we, b_we, wr_addr, wr_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (a_we !== !e.is_b || b_we !== e.is_b || wr_addr !== e.addr ||
                            wr_row !== e.row || wr_col !== e.col || wr_data !== e.data ||
                            load_done !== e.ld) begin
                            errors++;
                            $display("FAIL write_match: got a=%b b=%b addr=%0d r=%0d c=%0d d=%h ld=%b required a=%b b=%b addr=%0d r=%0d c=%0d d=%h ld=%b",
                                     a_we, b_we, wr_addr, wr_row, wr_col, wr_data, load_done,
                                     !e.is_b, e.is_b, e.addr, e.row, e.col, e.data, e.ld);
                        end
                    end
                end else if (load_done) begin
                    checks++;
                    errors++;
                    $display("FAIL lone_load_done: load_done=1 without b_we, required 0");
                end
            end
        join_none

        test_reset();
        test_full_3x3();
        test_bad_size();
        test_timeout();
        test_overrun();
        test_reset_mid_load();
        test_size1();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
